// File: rtl/layer0_input_deserializer.sv
// Packs one quantized feature per beat into a full activation vector for layer0, double-buffered.
// Optional frame counter output enabled by defining L0_DESER_FRAME_COUNT_EN.
module layer0_input_deserializer #(
  parameter int unsigned FEAT_BITS    = 2,
  parameter int unsigned NUM_FEATURES = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [FEAT_BITS-1:0]              s_data,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [NUM_FEATURES*FEAT_BITS-1:0] m_data,
`ifdef L0_DESER_FRAME_COUNT_EN
  output logic [CNT_W-1:0]                  frames_out,
`endif
  output logic                              err_frame
);

  localparam int unsigned IdxW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned VecW = NUM_FEATURES * FEAT_BITS;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_FEATURES - 1);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [VecW-1:0]   fill_buf_q, fill_buf_d;
  logic [VecW-1:0]   m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              err_q, err_d;
  logic [VecW-1:0]   merged;
  logic              accept, slot_free;

  assign s_ready   = (state_q == StFill);
  assign accept    = s_valid && s_ready;
  // A vector being drained this cycle frees the slot for an immediate reload.
  assign slot_free = !m_valid_q || m_ready;

  always_comb begin
    merged = fill_buf_q;
    merged[int'(idx_q)*FEAT_BITS +: FEAT_BITS] = s_data;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fill_buf_d = fill_buf_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    err_d      = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (idx_q == LastIdx) begin
            // Framing is length-based; a missing s_last only flags an error.
            err_d = !s_last;
            idx_d = '0;
            if (slot_free) begin
              m_data_d   = merged;
              m_valid_d  = 1'b1;
              fill_buf_d = '0;
            end else begin
              fill_buf_d = merged;
              state_d    = StFull;
            end
          end else if (s_last) begin
            err_d      = 1'b1;
            idx_d      = '0;
            fill_buf_d = '0;
          end else begin
            fill_buf_d = merged;
            idx_d      = idx_q + 1'b1;
          end
        end
      end
      StFull: begin
        if (slot_free) begin
          m_data_d   = fill_buf_q;
          m_valid_d  = 1'b1;
          fill_buf_d = '0;
          state_d    = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      idx_q      <= '0;
      fill_buf_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fill_buf_q <= fill_buf_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      err_q      <= err_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign err_frame = err_q;

`ifdef L0_DESER_FRAME_COUNT_EN
  logic [CNT_W-1:0] frames_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
    end else if (m_valid_q && m_ready) begin
      frames_q <= frames_q + 1'b1;
    end
  end

  assign frames_out = frames_q;
`endif

endmodule

// File: tb/tb_layer0_input_deserializer.sv
// Directed bench for layer0_input_deserializer with a queue of expected packed vectors.
module tb_layer0_input_deserializer;

  localparam int NF = 64;
  localparam int FB = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_last;
  logic [FB-1:0]    s_data;
  logic             m_valid, m_ready;
  logic [NF*FB-1:0] m_data;
  logic             err_frame;
`ifdef L0_DESER_FRAME_COUNT_EN
  logic [15:0]      frames_out;
`endif

  int vectors = 0;
  int errs    = 0;
  logic [NF*FB-1:0] exp_q[$];
  logic [NF*FB-1:0] front;

  layer0_input_deserializer #(
    .FEAT_BITS    (FB),
    .NUM_FEATURES (NF),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef L0_DESER_FRAME_COUNT_EN
    .frames_out (frames_out),
`endif
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NF*FB-1:0] obs, input logic [NF*FB-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] feat(input int seed, input int k);
    return FB'(k * (seed + 1) + seed);
  endfunction

  // Drives nbeats beats back to back from a negedge; returns at the negedge after the last edge.
  task automatic send_frame(input int seed, input int nbeats, input int last_at, input bit push,
                            input bit chk_pre);
    logic [NF*FB-1:0] v;
    v = '0;
    for (int k = 0; k < nbeats; k++) begin
      s_valid = 1'b1;
      s_data  = feat(seed, k);
      s_last  = (k == last_at);
      if (k < NF) v[k*FB +: FB] = feat(seed, k);
      if (chk_pre && k == NF - 1) chk("pre_final_m_valid", {127'b0, m_valid}, 128'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (push) exp_q.push_back(v);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    #12;
    chk("rst_s_ready", {127'b0, s_ready}, 128'd1);
    chk("rst_m_valid", {127'b0, m_valid}, 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_err", {127'b0, err_frame}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, k%4 pattern.
    send_frame(0, NF, NF - 1, 1'b1, 1'b1);
    chk("t1_m_valid", {127'b0, m_valid}, 128'd1);
    front = exp_q.pop_front();
    chk("t1_m_data", m_data, front);
    chk("t1_slot0", {126'b0, m_data[1:0]}, 128'd0);
    chk("t1_slot3", {126'b0, m_data[7:6]}, 128'd3);
    chk("t1_slot63", {126'b0, m_data[127:126]}, 128'd3);
    chk("t1_err", {127'b0, err_frame}, 128'd0);
    @(negedge clk);
    chk("t1_single_cycle", {127'b0, m_valid}, 128'd0);

    // Backpressure: A held, B fills, then FULL.
    m_ready = 1'b0;
    send_frame(1, NF, NF - 1, 1'b1, 1'b0);
    chk("t2_a_valid", {127'b0, m_valid}, 128'd1);
    chk("t2_a_data", m_data, exp_q[0]);
    send_frame(2, NF, NF - 1, 1'b1, 1'b0);
    chk("t2_a_held", m_data, exp_q[0]);
    chk("t2_full_s_ready", {127'b0, s_ready}, 128'd0);
    @(negedge clk);
    chk("t2_a_still_held", m_data, exp_q[0]);
    m_ready = 1'b1;
    front = exp_q.pop_front();
    chk("t2_a_consumed", m_data, front);
    @(negedge clk);
    chk("t2_b_valid", {127'b0, m_valid}, 128'd1);
    front = exp_q.pop_front();
    chk("t2_b_data", m_data, front);
    chk("t2_s_ready_back", {127'b0, s_ready}, 128'd1);
    @(negedge clk);
    chk("t2_drained", {127'b0, m_valid}, 128'd0);

    // Short frame: s_last on beat 10.
    send_frame(3, 10, 9, 1'b0, 1'b0);
    chk("t3_err_pulse", {127'b0, err_frame}, 128'd1);
    chk("t3_no_valid", {127'b0, m_valid}, 128'd0);
    @(negedge clk);
    chk("t3_err_single", {127'b0, err_frame}, 128'd0);
    send_frame(2, NF, NF - 1, 1'b1, 1'b1);
    chk("t3_next_valid", {127'b0, m_valid}, 128'd1);
    front = exp_q.pop_front();
    chk("t3_next_data", m_data, front);
    chk("t3_next_err", {127'b0, err_frame}, 128'd0);
    @(negedge clk);

    // Long frame: s_last never asserted.
    send_frame(1, NF, -1, 1'b1, 1'b0);
    chk("t4_valid", {127'b0, m_valid}, 128'd1);
    front = exp_q.pop_front();
    chk("t4_data", m_data, front);
    chk("t4_err_pulse", {127'b0, err_frame}, 128'd1);
    @(negedge clk);
    chk("t4_err_single", {127'b0, err_frame}, 128'd0);

    // Reset at beat 30.
    send_frame(3, 30, -1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {127'b0, m_valid}, 128'd0);
    chk("t5_rst_data", m_data, 128'd0);
    chk("t5_rst_s_ready", {127'b0, s_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(0, NF, NF - 1, 1'b1, 1'b1);
    chk("t5_after_valid", {127'b0, m_valid}, 128'd1);
    front = exp_q.pop_front();
    chk("t5_after_data", m_data, front);
    @(negedge clk);

    // Reset while a vector is held.
    m_ready = 1'b0;
    send_frame(3, NF, NF - 1, 1'b1, 1'b0);
    chk("t6_held_valid", {127'b0, m_valid}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    chk("t6_rst_valid", {127'b0, m_valid}, 128'd0);
    chk("t6_rst_data", m_data, 128'd0);
    chk("t6_rst_s_ready", {127'b0, s_ready}, 128'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    send_frame(1, NF, NF - 1, 1'b1, 1'b1);
    chk("t6_after_valid", {127'b0, m_valid}, 128'd1);
    front = exp_q.pop_front();
    chk("t6_after_data", m_data, front);
    @(negedge clk);
    chk("t6_drained", {127'b0, m_valid}, 128'd0);
`ifdef L0_DESER_FRAME_COUNT_EN
    chk("frames_out", {112'b0, frames_out}, 128'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
